cmd_ctrl: RTL and testbench
===========================

CMD_CTRL -- requirements
Module: cmd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data byte width, minimum 8.
REQ-002 SHALL have parameter ADDR_BITS, default 4, meaning register file address width.
REQ-003 SHALL have parameter RES_BYTES, default 2, meaning ALU result width in WIDTH-bit bytes.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, meaning inter-byte timeout in clk cycles; used only under CMD_TIMEOUT_EN.
REQ-005 SHALL have clk  input  1  single clock; all logic is on the rising edge.
REQ-006 SHALL have rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have rx_data  input  WIDTH  synchronised received byte.
REQ-008 SHALL have rx_valid  input  1  one-cycle pulse qualifying rx_data.
REQ-009 SHALL have fifo_full  input  1  TX FIFO full.
REQ-010 SHALL have alu_out  input  RES_BYTES*WIDTH  ALU result.
REQ-011 SHALL have alu_valid  input  1  ALU result valid.
REQ-012 SHALL have rf_rd_data  input  WIDTH, and rf_rd_valid  input  1: register file read data and its valid.
REQ-013 SHALL have rf_wr_en, rf_rd_en  output  1 each, rf_addr  output  ADDR_BITS, and rf_wr_data  output  WIDTH: register file access.
REQ-014 SHALL have alu_fun  output  4, alu_en  output  1, and gate_en  output  1: ALU function, start pulse and ALU clock-gate enable.
REQ-015 SHALL have tx_data  output  WIDTH, and tx_wr  output  1: FIFO write data and write strobe.
REQ-016 SHALL have busy  output  1 (state != IDLE) and err_timeout  output  1 (one-cycle timeout pulse).

Function
REQ-017 SHALL compare opcodes against the zero-extended values 0xAA (reg write), 0xBB (reg read), 0xCC (ALU with operands) and 0xDD (ALU without operands).
REQ-018 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT, TX_SEND.
REQ-019 In IDLE, on rx_valid: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OPA, 0xDD->FUN; any other byte is ignored and the FSM stays in IDLE.
REQ-020 In WR_ADDR, on rx_valid: latch rx_data[ADDR_BITS-1:0] and go to WR_DATA.
REQ-021 In WR_DATA, on rx_valid: rf_wr_en=1 for exactly one cycle with the latched rf_addr and rf_wr_data=rx_data, then go to IDLE.
REQ-022 In RD_ADDR, on rx_valid: rf_rd_en=1 for one cycle with rf_addr=rx_data[ADDR_BITS-1:0], then go to RD_WAIT.
REQ-023 In RD_WAIT, on rf_rd_valid: capture rf_rd_data as a 1-byte response and go to TX_SEND.
REQ-024 In OPA and OPB, on rx_valid: one-cycle register write to address 0 (OPA) or address 1 (OPB); OPA->OPB, OPB->FUN.
REQ-025 In FUN, on rx_valid: latch alu_fun=rx_data[3:0], pulse alu_en for one cycle, go to ALU_WAIT.
REQ-026 gate_en SHALL assert in the cycle FUN accepts a byte and deassert in the cycle after alu_valid is seen.
REQ-027 In ALU_WAIT, on alu_valid: capture all RES_BYTES bytes of alu_out and go to TX_SEND.
REQ-028 In TX_SEND, in each cycle with fifo_full=0: tx_wr=1 and tx_data=byte k, sent LSB byte first, then k increments.
REQ-029 In TX_SEND, in each cycle with fifo_full=1: tx_wr=0, k holds, and no data is lost.
REQ-030 TX_SEND SHALL go to IDLE after the last byte; a read response is 1 byte, an ALU response is RES_BYTES bytes.
REQ-031 rx_valid SHALL be ignored in RD_WAIT, ALU_WAIT and TX_SEND.
REQ-032 alu_valid and rf_rd_valid SHALL be ignored outside ALU_WAIT and RD_WAIT respectively.
REQ-033 All outputs SHALL be registered; a byte accepted at edge n produces its strobe in the cycle after edge n.

Reset
REQ-034 When rstn=0, the FSM SHALL go to IDLE at once, including mid-command.
REQ-035 When rstn=0, all outputs, the byte index, the response buffer and the timeout counter SHALL be 0.
REQ-036 After rstn rises, the first rx_valid SHALL be decoded as an opcode.

Configuration
REQ-037 With macro CMD_TIMEOUT_EN defined, a counter SHALL clear on every state change and on every rx_valid, and SHALL count in WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN and ALU_WAIT.
REQ-038 With CMD_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC-1 the FSM SHALL go to IDLE, pulse err_timeout for one cycle, deassert gate_en, and write nothing.
REQ-039 Without CMD_TIMEOUT_EN, err_timeout SHALL be tied to 0, no counter SHALL exist, and the wait states hold indefinitely.

Verification
REQ-040 Bench SHALL drive bytes AA,05,3C -> one rf_wr_en cycle with rf_addr=5 and rf_wr_data=0x3C; busy returns to 0.
REQ-041 Bench SHALL drive BB,05, then rf_rd_valid with 0x3C -> one tx_wr with tx_data=0x3C.
REQ-042 Bench SHALL drive CC,10,20,00 and then alu_out=0x0030 -> writes addr0=0x10 and addr1=0x20, alu_en pulse with fun=0, then tx_wr bytes 0x30 then 0x00.
REQ-043 Bench SHALL drive DD,02 with fifo_full held high for 5 cycles after alu_valid -> no tx_wr for those 5 cycles, then both bytes in order.
REQ-044 Bench SHALL drive 0x55 in IDLE, then AA,07 and assert rstn=0 -> 0x55 is ignored; after reset no write occurs and the next AA is decoded as an opcode.
REQ-045 With CMD_TIMEOUT_EN and TIMEOUT_CYC=16, bench SHALL drive AA then idle for 20 cycles -> err_timeout pulse 16 cycles after AA, return to IDLE, no rf_wr_en.

Source files
------------

// File: rtl/cmd_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : cmd_ctrl_if                                                |
// | Purpose  : Bundles the byte stream, register file, ALU and TX FIFO    |
// |            signals of the command controller.                         |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface cmd_ctrl_if #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 4,
  parameter int RES_BYTES = 2
);
  logic [WIDTH-1:0]           rx_data;
  logic                       rx_valid;
  logic                       fifo_full;
  logic [RES_BYTES*WIDTH-1:0] alu_out;
  logic                       alu_valid;
  logic [WIDTH-1:0]           rf_rd_data;
  logic                       rf_rd_valid;
  logic                       rf_wr_en;
  logic                       rf_rd_en;
  logic [ADDR_BITS-1:0]       rf_addr;
  logic [WIDTH-1:0]           rf_wr_data;
  logic [3:0]                 alu_fun;
  logic                       alu_en;
  logic                       gate_en;
  logic [WIDTH-1:0]           tx_data;
  logic                       tx_wr;
  logic                       busy;
  logic                       err_timeout;

  // Controller side
  modport master (
    input  rx_data, rx_valid, fifo_full, alu_out, alu_valid, rf_rd_data, rf_rd_valid,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_fun, alu_en, gate_en,
           tx_data, tx_wr, busy, err_timeout
  );

  // Environment side (receiver, register file, ALU, FIFO)
  modport slave (
    output rx_data, rx_valid, fifo_full, alu_out, alu_valid, rf_rd_data, rf_rd_valid,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_fun, alu_en, gate_en,
           tx_data, tx_wr, busy, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/cmd_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : cmd_ctrl                                                   |
// | Purpose  : Byte-stream command decoder driving a register file and    |
// |            an ALU, returning responses through a TX FIFO.             |
// |            Optional inter-byte timeout enabled by macro CMD_TIMEOUT_EN.|
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module cmd_ctrl #(
  parameter int WIDTH       = 8,
  parameter int ADDR_BITS   = 4,
  parameter int RES_BYTES   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  cmd_ctrl_if.master  bus
);

  localparam int c_BUF_W = RES_BYTES * WIDTH;
  localparam int c_K_W   = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

  localparam logic [WIDTH-1:0] c_OP_WR  = WIDTH'(8'hAA);
  localparam logic [WIDTH-1:0] c_OP_RD  = WIDTH'(8'hBB);
  localparam logic [WIDTH-1:0] c_OP_ALU = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] c_OP_FUN = WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    OPA      = 4'd5,
    OPB      = 4'd6,
    FUN      = 4'd7,
    ALU_WAIT = 4'd8,
    TX_SEND  = 4'd9
  } state_t;

  state_t               r_state,      w_state;
  logic [c_BUF_W-1:0]   r_buf,        w_buf;
  logic [c_K_W-1:0]     r_k,          w_k;
  logic [c_K_W-1:0]     r_last,       w_last;
  logic                 r_rf_wr_en,   w_rf_wr_en;
  logic                 r_rf_rd_en,   w_rf_rd_en;
  logic [ADDR_BITS-1:0] r_rf_addr,    w_rf_addr;
  logic [WIDTH-1:0]     r_rf_wr_data, w_rf_wr_data;
  logic [3:0]           r_alu_fun,    w_alu_fun;
  logic                 r_alu_en,     w_alu_en;
  logic                 r_gate_en,    w_gate_en;
  logic [WIDTH-1:0]     r_tx_data,    w_tx_data;
  logic                 r_tx_wr,      w_tx_wr;
  logic                 r_busy,       w_busy;

`ifdef CMD_TIMEOUT_EN
  localparam int c_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [c_CNT_W-1:0]   r_cnt,        w_cnt;
  logic                 r_err,        w_err;
`endif

  // Next-state and next-output decode; every output is registered from these
  always_comb begin
    w_state      = r_state;
    w_buf        = r_buf;
    w_k          = r_k;
    w_last       = r_last;
    w_rf_wr_en   = 1'b0;
    w_rf_rd_en   = 1'b0;
    w_rf_addr    = r_rf_addr;
    w_rf_wr_data = r_rf_wr_data;
    w_alu_fun    = r_alu_fun;
    w_alu_en     = 1'b0;
    w_gate_en    = r_gate_en;
    w_tx_data    = r_tx_data;
    w_tx_wr      = 1'b0;
`ifdef CMD_TIMEOUT_EN
    w_cnt        = r_cnt;
    w_err        = 1'b0;
`endif

    case (r_state)
      IDLE: begin
        if (bus.rx_valid) begin
          if      (bus.rx_data == c_OP_WR)  w_state = WR_ADDR;
          else if (bus.rx_data == c_OP_RD)  w_state = RD_ADDR;
          else if (bus.rx_data == c_OP_ALU) w_state = OPA;
          else if (bus.rx_data == c_OP_FUN) w_state = FUN;
        end
      end
      WR_ADDR: begin
        if (bus.rx_valid) begin
          w_rf_addr = bus.rx_data[ADDR_BITS-1:0];
          w_state   = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.rx_valid) begin
          w_rf_wr_en   = 1'b1;
          w_rf_wr_data = bus.rx_data;
          w_state      = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.rx_valid) begin
          w_rf_rd_en = 1'b1;
          w_rf_addr  = bus.rx_data[ADDR_BITS-1:0];
          w_state    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bus.rf_rd_valid) begin
          w_buf   = c_BUF_W'(bus.rf_rd_data);
          w_k     = '0;
          w_last  = '0;
          w_state = TX_SEND;
        end
      end
      OPA: begin
        if (bus.rx_valid) begin
          w_rf_wr_en   = 1'b1;
          w_rf_addr    = '0;
          w_rf_wr_data = bus.rx_data;
          w_state      = OPB;
        end
      end
      OPB: begin
        if (bus.rx_valid) begin
          w_rf_wr_en   = 1'b1;
          w_rf_addr    = ADDR_BITS'(1);
          w_rf_wr_data = bus.rx_data;
          w_state      = FUN;
        end
      end
      FUN: begin
        if (bus.rx_valid) begin
          w_alu_fun = bus.rx_data[3:0];
          w_alu_en  = 1'b1;
          w_gate_en = 1'b1;
          w_state   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (bus.alu_valid) begin
          w_buf     = bus.alu_out;
          w_k       = '0;
          w_last    = c_K_W'(RES_BYTES - 1);
          w_gate_en = 1'b0;
          w_state   = TX_SEND;
        end
      end
      TX_SEND: begin
        // A full FIFO simply stalls: buffer and index are left untouched
        if (!bus.fifo_full) begin
          w_tx_wr   = 1'b1;
          w_tx_data = r_buf[WIDTH-1:0];
          w_buf     = r_buf >> WIDTH;
          if (r_k == r_last) begin
            w_k     = '0;
            w_state = IDLE;
          end else begin
            w_k = r_k + 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase

`ifdef CMD_TIMEOUT_EN
    // Any progress restarts the inter-byte timer; a stall aborts the command
    if ((w_state != r_state) || bus.rx_valid) begin
      w_cnt = '0;
    end else if (r_state inside {WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, FUN, ALU_WAIT}) begin
      if (r_cnt == c_CNT_W'(TIMEOUT_CYC - 1)) begin
        w_state   = IDLE;
        w_err     = 1'b1;
        w_gate_en = 1'b0;
        w_cnt     = '0;
      end else begin
        w_cnt = r_cnt + 1'b1;
      end
    end
`endif

    w_busy = (w_state != IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_buf        <= '0;
      r_k          <= '0;
      r_last       <= '0;
      r_rf_wr_en   <= 1'b0;
      r_rf_rd_en   <= 1'b0;
      r_rf_addr    <= '0;
      r_rf_wr_data <= '0;
      r_alu_fun    <= '0;
      r_alu_en     <= 1'b0;
      r_gate_en    <= 1'b0;
      r_tx_data    <= '0;
      r_tx_wr      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_buf        <= w_buf;
      r_k          <= w_k;
      r_last       <= w_last;
      r_rf_wr_en   <= w_rf_wr_en;
      r_rf_rd_en   <= w_rf_rd_en;
      r_rf_addr    <= w_rf_addr;
      r_rf_wr_data <= w_rf_wr_data;
      r_alu_fun    <= w_alu_fun;
      r_alu_en     <= w_alu_en;
      r_gate_en    <= w_gate_en;
      r_tx_data    <= w_tx_data;
      r_tx_wr      <= w_tx_wr;
      r_busy       <= w_busy;
    end
  end

`ifdef CMD_TIMEOUT_EN
  // Timeout counter and its one-cycle error strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt;
      r_err <= w_err;
    end
  end

  assign bus.err_timeout = r_err;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.rf_wr_en   = r_rf_wr_en;
  assign bus.rf_rd_en   = r_rf_rd_en;
  assign bus.rf_addr    = r_rf_addr;
  assign bus.rf_wr_data = r_rf_wr_data;
  assign bus.alu_fun    = r_alu_fun;
  assign bus.alu_en     = r_alu_en;
  assign bus.gate_en    = r_gate_en;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_wr      = r_tx_wr;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cmd_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_cmd_ctrl                                                |
// | Purpose  : Self-checking bench for cmd_ctrl: command-level reference  |
// |            model compared every cycle, directed command scenarios     |
// |            and randomized byte traffic.                               |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_cmd_ctrl;
  localparam int W  = 8;
  localparam int AB = 4;
  localparam int RB = 2;
  localparam int TO = 16;

  localparam logic [W-1:0] OP_WR  = 8'hAA;
  localparam logic [W-1:0] OP_RD  = 8'hBB;
  localparam logic [W-1:0] OP_ALU = 8'hCC;
  localparam logic [W-1:0] OP_FUN = 8'hDD;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cmd_ctrl_if #(.WIDTH(W), .ADDR_BITS(AB), .RES_BYTES(RB)) bus ();

  cmd_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .RES_BYTES(RB), .TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int ck_total = 0;
  int ck_pass  = 0;
  int fail_prints = 0;
  int cyc = 0;
  int tick_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ck_total++;
    if (act === exp) ck_pass++;
    else if (fail_prints < 40) begin
      fail_prints++;
      $display("FAIL %s @cyc %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- command-level reference model ----------------
  // Tracks the bytes of the command in progress, what it is waiting for and
  // the queue of response bytes still to be sent.
  logic [W-1:0]  m_cmd[$];
  int            m_wait  = 0;   // 0 nothing, 1 read data, 2 ALU result
  logic [W-1:0]  m_tx[$];
  int            m_quiet = 0;

  logic          e_wr_en = 0, e_rd_en = 0, e_alu_en = 0, e_gate = 0;
  logic          e_tx_wr = 0, e_busy = 0, e_err = 0;
  logic [AB-1:0] e_addr = '0;
  logic [W-1:0]  e_wr_data = '0, e_tx_data = '0;
  logic [3:0]    e_fun = '0;

  task automatic model_fun(input logic [W-1:0] b);
    e_fun    = b[3:0];
    e_alu_en = 1'b1;
    e_gate   = 1'b1;
    m_cmd.delete();
    m_wait   = 2;
  endtask

  task automatic model_step();
    logic [W-1:0] b;
    bit in_wait, ev;
    e_wr_en = 0; e_rd_en = 0; e_alu_en = 0; e_tx_wr = 0; e_err = 0;
    in_wait = (m_cmd.size() != 0) || (m_wait != 0);
    ev      = bus.rx_valid;
    if (m_tx.size() != 0) begin
      if (!bus.fifo_full) begin
        e_tx_wr   = 1'b1;
        e_tx_data = m_tx.pop_front();
      end
    end else if (m_wait == 1) begin
      if (bus.rf_rd_valid) begin
        m_tx.push_back(bus.rf_rd_data);
        m_wait = 0; ev = 1;
      end
    end else if (m_wait == 2) begin
      if (bus.alu_valid) begin
        for (int i = 0; i < RB; i++) m_tx.push_back(bus.alu_out[i*W +: W]);
        m_wait = 0; e_gate = 0; ev = 1;
      end
    end else if (bus.rx_valid) begin
      b = bus.rx_data;
      if (m_cmd.size() == 0) begin
        if (b == OP_WR || b == OP_RD || b == OP_ALU || b == OP_FUN) m_cmd.push_back(b);
      end else begin
        m_cmd.push_back(b);
        if (m_cmd[0] == OP_WR) begin
          if (m_cmd.size() == 2) e_addr = b[AB-1:0];
          else begin e_wr_en = 1; e_wr_data = b; m_cmd.delete(); end
        end else if (m_cmd[0] == OP_RD) begin
          e_rd_en = 1; e_addr = b[AB-1:0]; m_cmd.delete(); m_wait = 1;
        end else if (m_cmd[0] == OP_ALU) begin
          if (m_cmd.size() == 4) model_fun(b);
          else begin
            e_wr_en = 1; e_wr_data = b;
            e_addr = (m_cmd.size() == 2) ? AB'(0) : AB'(1);
          end
        end else begin
          model_fun(b);
        end
      end
    end
`ifdef CMD_TIMEOUT_EN
    if (!in_wait || ev) m_quiet = 0;
    else if (m_quiet == TO - 1) begin
      m_cmd.delete(); m_wait = 0; e_gate = 0; e_err = 1; m_quiet = 0;
    end else m_quiet++;
`else
    if (in_wait && ev) m_quiet = 0;
`endif
    e_busy = (m_cmd.size() != 0) || (m_wait != 0) || (m_tx.size() != 0);
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_cmd.delete(); m_tx.delete(); m_wait = 0; m_quiet = 0;
      e_wr_en = 0; e_rd_en = 0; e_alu_en = 0; e_gate = 0; e_tx_wr = 0;
      e_busy = 0; e_err = 0; e_addr = '0; e_wr_data = '0; e_tx_data = '0; e_fun = '0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare and event logs ----------------
  logic [AB-1:0] wr_a_q[$];
  logic [W-1:0]  wr_d_q[$];
  logic [W-1:0]  tx_q[$];
  logic [3:0]    fun_q[$];
  int            err_q[$];

  initial begin : compare_proc
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      chk("rf_wr_en",    bus.rf_wr_en,    e_wr_en);
      chk("rf_rd_en",    bus.rf_rd_en,    e_rd_en);
      chk("rf_addr",     bus.rf_addr,     e_addr);
      chk("rf_wr_data",  bus.rf_wr_data,  e_wr_data);
      chk("alu_fun",     bus.alu_fun,     e_fun);
      chk("alu_en",      bus.alu_en,      e_alu_en);
      chk("gate_en",     bus.gate_en,     e_gate);
      chk("tx_wr",       bus.tx_wr,       e_tx_wr);
      chk("tx_data",     bus.tx_data,     e_tx_data);
      chk("busy",        bus.busy,        e_busy);
      chk("err_timeout", bus.err_timeout, e_err);
      if (bus.rf_wr_en) begin wr_a_q.push_back(bus.rf_addr); wr_d_q.push_back(bus.rf_wr_data); end
      if (bus.tx_wr) tx_q.push_back(bus.tx_data);
      if (bus.alu_en) fun_q.push_back(bus.alu_fun);
      if (bus.err_timeout) err_q.push_back(cyc);
    end
  end

  // ---------------- environment: register file and ALU responders ----------------
  logic [W-1:0]    mem [0:(1<<AB)-1];
  logic [AB-1:0]   rd_addr = '0;
  int              alu_cnt = 0, rd_cnt = 0;
  logic [RB*W-1:0] alu_res = '0;
  bit              alu_rand = 0, spur = 0, alu_pulsed = 0;

  task automatic tick(input bit rv, input logic [W-1:0] rd, input bit ff);
    @(negedge clk);
    tick_cyc = cyc;
    bus.rx_valid    = rv;
    bus.rx_data     = rd;
    bus.fifo_full   = ff;
    bus.alu_valid   = 1'b0;
    bus.rf_rd_valid = 1'b0;
    alu_pulsed      = 0;
    if (bus.rf_wr_en) mem[bus.rf_addr] = bus.rf_wr_data;
    if (bus.alu_en) alu_cnt = $urandom_range(1, 4);
    else if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        bus.alu_valid = 1'b1;
        bus.alu_out   = alu_rand ? (RB*W)'($urandom) : alu_res;
        alu_pulsed    = 1;
      end
    end else if (spur && $urandom_range(0, 29) == 0) begin
      bus.alu_valid = 1'b1;
      bus.alu_out   = (RB*W)'($urandom);
    end
    if (bus.rf_rd_en) begin rd_cnt = $urandom_range(1, 4); rd_addr = bus.rf_addr; end
    else if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin bus.rf_rd_valid = 1'b1; bus.rf_rd_data = mem[rd_addr]; end
    end else if (spur && $urandom_range(0, 29) == 0) begin
      bus.rf_rd_valid = 1'b1;
      bus.rf_rd_data  = W'($urandom);
    end
  endtask

  task automatic send(input logic [W-1:0] b);
    tick(1'b1, b, 1'b0);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin tick(1'b0, '0, 1'b0); n++; end while (bus.busy && n < bound);
    if (bus.busy) begin
      ck_total++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", bound);
    end
  endtask

  task automatic clear_logs();
    wr_a_q.delete(); wr_d_q.delete(); tx_q.delete(); fun_q.delete(); err_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    alu_cnt = 0; rd_cnt = 0;
    bus.rx_valid = 1'b0; bus.alu_valid = 1'b0; bus.rf_rd_valid = 1'b0; bus.fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios then random traffic ----------------
  initial begin : main
    int aa_cyc;
    logic [W-1:0] b;
    for (int i = 0; i < (1 << AB); i++) mem[i] = '0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.fifo_full = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_out = '0; bus.rf_rd_valid = 1'b0; bus.rf_rd_data = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    tick(1'b0, '0, 1'b0);
    chk("reset_busy",   bus.busy,        0);
    chk("reset_wr_en",  bus.rf_wr_en,    0);
    chk("reset_tx_wr",  bus.tx_wr,       0);
    chk("reset_err",    bus.err_timeout, 0);
    chk("reset_addr",   bus.rf_addr,     0);

    // register write
    clear_logs();
    send(8'hAA); send(8'h05); send(8'h3C);
    wait_idle(20);
    chk("wr_count", wr_a_q.size(), 1);
    chk("wr_addr",  wr_a_q[0], 5);
    chk("wr_data",  wr_d_q[0], 8'h3C);
    chk("wr_busy",  bus.busy, 0);

    // register read returns one byte
    clear_logs();
    send(8'hBB); send(8'h05);
    wait_idle(30);
    chk("rd_tx_count", tx_q.size(), 1);
    chk("rd_tx_byte",  tx_q[0], 8'h3C);

    // ALU with operands
    clear_logs();
    alu_res = 16'h0030;
    send(8'hCC); send(8'h10); send(8'h20); send(8'h00);
    wait_idle(30);
    chk("opa_opb_count", wr_a_q.size(), 2);
    chk("opa_addr",  wr_a_q[0], 0);
    chk("opa_data",  wr_d_q[0], 8'h10);
    chk("opb_addr",  wr_a_q[1], 1);
    chk("opb_data",  wr_d_q[1], 8'h20);
    chk("alu_en_count", fun_q.size(), 1);
    chk("alu_fun0",  fun_q[0], 0);
    chk("alu_tx_count", tx_q.size(), 2);
    chk("alu_tx_lsb", tx_q[0], 8'h30);
    chk("alu_tx_msb", tx_q[1], 8'h00);

    // ALU without operands, FIFO full for 5 cycles after the result
    clear_logs();
    alu_res = 16'hA55A;
    send(8'hDD); send(8'h02);
    for (int i = 0; i < 20 && !alu_pulsed; i++) tick(1'b0, '0, 1'b0);
    chk("alu_valid_seen", alu_pulsed, 1);
    repeat (5) tick(1'b0, '0, 1'b1);
    chk("full_no_tx", tx_q.size(), 0);
    wait_idle(20);
    chk("full_fun", fun_q[0], 2);
    chk("full_tx_count", tx_q.size(), 2);
    chk("full_tx_lsb", tx_q[0], 8'h5A);
    chk("full_tx_msb", tx_q[1], 8'hA5);

    // garbage byte ignored, reset mid-command
    clear_logs();
    send(8'h55);
    tick(1'b0, '0, 1'b0);
    chk("ignore_55_busy", bus.busy, 0);
    send(8'hAA); send(8'h07);
    do_reset();
    tick(1'b0, '0, 1'b0);
    chk("midreset_busy", bus.busy, 0);
    send(8'hAA); send(8'h09); send(8'h5A);
    wait_idle(20);
    chk("after_reset_wr_count", wr_a_q.size(), 1);
    chk("after_reset_addr", wr_a_q[0], 9);
    chk("after_reset_data", wr_d_q[0], 8'h5A);

    // stalled command
    clear_logs();
    send(8'hAA);
    aa_cyc = tick_cyc;
    repeat (20) tick(1'b0, '0, 1'b0);
`ifdef CMD_TIMEOUT_EN
    chk("to_pulse_count", err_q.size(), 1);
    chk("to_pulse_delay", err_q[0] - aa_cyc, 17);
    chk("to_busy", bus.busy, 0);
    chk("to_no_write", wr_a_q.size(), 0);
`else
    chk("hold_no_err", err_q.size(), 0);
    chk("hold_busy", bus.busy, 1);
    send(8'h07); send(8'h11);
    wait_idle(20);
    chk("hold_wr_addr", wr_a_q[0], 7);
    chk("hold_wr_data", wr_d_q[0], 8'h11);
`endif

    // random traffic
    alu_rand = 1; spur = 1;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: b = OP_WR;
        1: b = OP_RD;
        2: b = OP_ALU;
        3: b = OP_FUN;
        default: b = W'($urandom);
      endcase
      tick($urandom_range(0, 2) == 0, b, $urandom_range(0, 3) == 0);
      if (n == 1500) do_reset();
    end
    spur = 0;
    wait_idle(200);

    $display("%0d/%0d checks passed", ck_pass, ck_total);
    $finish;
  end

endmodule
`default_nettype wire
